// File: rtl/ldm_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ldm_writeback_sequencer
// Desc   : ARM LDM sequencer: register list -> word reads -> RF writebacks,
//          optional base writeback. Macro LDM_PC_FLUSH_EN adds flush outputs.
// Rev    : 1.0  initial release
// ============================================================================
module ldm_writeback_sequencer #(
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned WORD_BYTES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_REGS-1:0]         reg_list,
   input  logic [31:0]                 base_addr,
   input  logic [$clog2(NUM_REGS)-1:0] base_reg,
   input  logic                        up,
   input  logic                        wback,
   output logic                        mem_req,
   output logic [31:0]                 mem_addr,
   input  logic                        mem_ready,
   input  logic [31:0]                 mem_rdata,
   output logic [$clog2(NUM_REGS)-1:0] Dest_wb,
   output logic [31:0]                 Result_WB,
   output logic                        writeBackEn,
   output logic                        busy,
`ifdef LDM_PC_FLUSH_EN
   output logic                        flush,
   output logic [31:0]                 branch_target,
`endif
   output logic                        done
);

   localparam int c_IDX_W = $clog2(NUM_REGS);
   localparam int c_CNT_W = $clog2(NUM_REGS + 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_LOAD  = 2'd1;
   localparam logic [1:0] c_WBASE = 2'd2;
   localparam logic [1:0] c_FIN   = 2'd3;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic [NUM_REGS-1:0] r_list;
   logic [c_IDX_W-1:0]  r_base_reg;
   logic                r_wback_go;
   logic [31:0]         r_new_base;
   logic [31:0]         r_addr;
   logic                r_wb_en;
   logic [c_IDX_W-1:0]  r_wb_idx;
   logic [31:0]         r_wb_data;
   logic                r_done;

   logic [c_CNT_W-1:0]  w_count;
   logic [31:0]         w_span;
   logic [c_IDX_W-1:0]  w_low_idx;
   logic [NUM_REGS-1:0] w_list_rest;
   logic                w_last_load;

   always_comb begin
      w_count = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_count = w_count + c_CNT_W'(reg_list[i]);
      end
   end

   assign w_span = 32'(w_count) * 32'(WORD_BYTES);

   // Scan downward so the lowest set bit is the last one to win.
   always_comb begin
      w_low_idx = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (r_list[i]) w_low_idx = c_IDX_W'(i);
      end
   end

   assign w_list_rest = r_list & (r_list - NUM_REGS'(1));
   assign w_last_load = (w_list_rest == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  if (start) w_next_state = (w_count == '0) ? c_FIN : c_LOAD;
         c_LOAD:  if (mem_ready && w_last_load) w_next_state = r_wback_go ? c_WBASE : c_FIN;
         c_WBASE: w_next_state = c_FIN;
         c_FIN:   w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      mem_req = (r_state == c_LOAD);
      busy    = (r_state != c_IDLE);
   end

   // Writeback outputs are registered: each write appears the cycle after
   // the state that issued it, and done trails FIN by one cycle likewise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_list     <= '0;
         r_base_reg <= '0;
         r_wback_go <= 1'b0;
         r_new_base <= '0;
         r_addr     <= '0;
         r_wb_en    <= 1'b0;
         r_wb_idx   <= '0;
         r_wb_data  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_wb_en <= 1'b0;
         r_done  <= (r_state == c_FIN);
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_list     <= reg_list;
                  r_base_reg <= base_reg;
                  r_wback_go <= wback & ~reg_list[base_reg];
                  r_new_base <= up ? (base_addr + w_span) : (base_addr - w_span);
                  r_addr     <= up ? base_addr : (base_addr - w_span);
               end
            end
            c_LOAD: begin
               if (mem_ready) begin
                  r_wb_en   <= 1'b1;
                  r_wb_idx  <= w_low_idx;
                  r_wb_data <= mem_rdata;
                  r_list    <= w_list_rest;
                  r_addr    <= r_addr + 32'(WORD_BYTES);
               end
            end
            c_WBASE: begin
               r_wb_en   <= 1'b1;
               r_wb_idx  <= r_base_reg;
               r_wb_data <= r_new_base;
            end
            default: ;
         endcase
      end
   end

   assign mem_addr    = r_addr;
   assign Dest_wb     = r_wb_idx;
   assign Result_WB   = r_wb_data;
   assign writeBackEn = r_wb_en;
   assign done        = r_done;

`ifdef LDM_PC_FLUSH_EN
   localparam logic [c_IDX_W-1:0] c_PC_IDX = c_IDX_W'(NUM_REGS - 1);

   logic        r_flush;
   logic [31:0] r_branch_target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush         <= 1'b0;
         r_branch_target <= '0;
      end else begin
         r_flush <= 1'b0;
         if (r_state == c_LOAD && mem_ready && w_low_idx == c_PC_IDX) begin
            r_flush         <= 1'b1;
            r_branch_target <= mem_rdata & ~32'h3;
         end else if (r_state == c_WBASE && r_base_reg == c_PC_IDX) begin
            r_flush         <= 1'b1;
            r_branch_target <= r_new_base & ~32'h3;
         end
      end
   end

   assign flush         = r_flush;
   assign branch_target = r_branch_target;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldm_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ldm_writeback_sequencer
// Desc   : Self-checking bench: queue-based LDM model plus directed literals.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ldm_writeback_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] reg_list;
   logic [31:0] base_addr;
   logic [3:0]  base_reg;
   logic        up;
   logic        wback;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [3:0]  Dest_wb;
   logic [31:0] Result_WB;
   logic        writeBackEn;
   logic        busy;
   logic        done;

   ldm_writeback_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
      .base_addr(base_addr), .base_reg(base_reg), .up(up), .wback(wback),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
      .writeBackEn(writeBackEn), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address.
   assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Ready generator: mode 0 always ready, mode 1 three wait cycles per read.
   int rdy_mode = 0;
   int wcnt     = 0;
   always @(posedge clk) begin
      #2;
      if (rdy_mode == 0) begin
         mem_ready = 1'b1;
      end else if (!mem_req) begin
         mem_ready = 1'b0;
         wcnt      = 0;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
         wcnt      = 1;
      end else if (wcnt == 3) begin
         mem_ready = 1'b1;
      end else begin
         wcnt++;
      end
   end

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] data;
      bit          is_base;
   } wr_t;

   wr_t         exp_writes[$];
   logic [31:0] exp_reads[$];
   bit          m_active = 0;
   bit          acc_prev = 0;
   bit          base_due = 0;
   int          done_cd  = 0;

   logic [31:0] log_addr[$];
   logic [3:0]  log_idx[$];
   logic [31:0] log_data[$];
   int          stall_cnt   = 0;
   int          req_cnt     = 0;
   int          start_cyc   = 0;
   int          done_cyc    = 0;
   int          last_we_cyc = 0;

   always @(negedge clk) begin : compare
      bit          exp_done, exp_we, exp_req;
      wr_t         w;
      int          n, k;
      logic [31:0] span, sa, nb;
      if (rst) begin
         chk("reset_ctrl", {mem_req, busy, done, writeBackEn, Dest_wb}, 0);
         chk("reset_data", {mem_addr, Result_WB}, 0);
         exp_writes.delete();
         exp_reads.delete();
         m_active = 0; acc_prev = 0; base_due = 0; done_cd = 0;
      end else begin
         exp_done = (done_cd == 1);
         if (done_cd > 0) done_cd--;
         chk("busy", busy, m_active && !exp_done);
         chk("done", done, exp_done);
         if (exp_done) m_active = 0;
         if (done) done_cyc = cyc;

         exp_we   = acc_prev || base_due;
         base_due = 0;
         chk("writeBackEn", writeBackEn, exp_we);
         if (exp_we && exp_writes.size() > 0) begin
            w = exp_writes.pop_front();
            chk("Dest_wb", Dest_wb, w.idx);
            chk("Result_WB", Result_WB, w.data);
            if (!w.is_base && exp_writes.size() > 0 && exp_writes[0].is_base) base_due = 1;
            if (exp_writes.size() == 0) done_cd = 1;
         end
         if (writeBackEn) begin
            log_idx.push_back(Dest_wb);
            log_data.push_back(Result_WB);
            last_we_cyc = cyc;
         end

         exp_req = (exp_reads.size() > 0);
         chk("mem_req", mem_req, exp_req);
         if (mem_req) req_cnt++;
         if (exp_req) begin
            chk("mem_addr", mem_addr, exp_reads[0]);
            if (!mem_ready) stall_cnt++;
         end
         acc_prev = exp_req && mem_ready;
         if (acc_prev) log_addr.push_back(exp_reads.pop_front());

         if (start && !m_active) begin
            n = 0;
            for (int i = 0; i < 16; i++) if (reg_list[i]) n++;
            span = 32'(n * 4);
            sa   = up ? base_addr : base_addr - span;
            nb   = up ? base_addr + span : base_addr - span;
            k    = 0;
            for (int i = 0; i < 16; i++) begin
               if (reg_list[i]) begin
                  exp_reads.push_back(sa + 32'(4 * k));
                  w.idx     = 4'(i);
                  w.data    = (sa + 32'(4 * k)) ^ 32'hDEAD_0000;
                  w.is_base = 0;
                  exp_writes.push_back(w);
                  k++;
               end
            end
            if (n > 0 && wback && !reg_list[base_reg]) begin
               w.idx = base_reg; w.data = nb; w.is_base = 1;
               exp_writes.push_back(w);
            end
            m_active  = 1;
            start_cyc = cyc;
            if (n == 0) done_cd = 2;
         end
      end
   end

   task automatic clear_logs();
      log_addr.delete(); log_idx.delete(); log_data.delete();
      stall_cnt = 0; req_cnt = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 300);
      chk("done_timeout", done, 1);
      @(posedge clk); #1;
   endtask

   task automatic launch(input logic [15:0] l, input logic [31:0] b, input logic [3:0] br,
                         input logic u, input logic wb);
      @(posedge clk); #1;
      clear_logs();
      reg_list = l; base_addr = b; base_reg = br; up = u; wback = wb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b0; start = 1'b0; reg_list = '0; base_addr = '0; base_reg = '0;
      up = 1'b0; wback = 1'b0; mem_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("lit_reset_busy", busy, 0);
      chk("lit_reset_we", writeBackEn, 0);
      #1 rst = 1'b0;

      // Increment-after with base writeback.
      launch(16'h0007, 32'h100, 4'd4, 1'b1, 1'b1);
      wait_done();
      chk("lit_t1_nwrites", log_idx.size(), 4);
      chk("lit_t1_addr0", log_addr[0], 32'h100);
      chk("lit_t1_addr2", log_addr[2], 32'h108);
      chk("lit_t1_r0", {log_idx[0], log_data[0]}, {4'd0, 32'hDEAD_0100});
      chk("lit_t1_r2", {log_idx[2], log_data[2]}, {4'd2, 32'hDEAD_0108});
      chk("lit_t1_base", {log_idx[3], log_data[3]}, {4'd4, 32'h10C});

      // Decrement-before including R15.
      launch(16'h8010, 32'h200, 4'd13, 1'b0, 1'b1);
      wait_done();
      chk("lit_t2_addr0", log_addr[0], 32'h1F8);
      chk("lit_t2_addr1", log_addr[1], 32'h1FC);
      chk("lit_t2_r15", {log_idx[1], log_data[1]}, {4'd15, 32'hDEAD_01FC});
      chk("lit_t2_base", {log_idx[2], log_data[2]}, {4'd13, 32'h1F8});

      // Base register in the list: loaded value wins, no base write.
      launch(16'h0022, 32'h300, 4'd5, 1'b1, 1'b1);
      wait_done();
      chk("lit_t3_nwrites", log_idx.size(), 2);
      chk("lit_t3_r5", {log_idx[1], log_data[1]}, {4'd5, 32'hDEAD_0304});
      chk("lit_t3_done_gap", done_cyc - last_we_cyc, 1);

      // Slow memory plus an ignored start while busy.
      @(posedge clk); #1 rdy_mode = 1;
      launch(16'h0300, 32'h400, 4'd2, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1 start = 1'b1; reg_list = 16'h0001; base_addr = 32'h900;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);
      chk("lit_t4_nwrites", log_idx.size(), 2);
      chk("lit_t4_r9", {log_idx[1], log_data[1]}, {4'd9, 32'hDEAD_0404});
      chk("lit_t4_stalls", stall_cnt, 6);
      chk("lit_t4_req_cycles", req_cnt, 8);
      chk("lit_t4_idle_busy", busy, 0);
      @(posedge clk); #1 rdy_mode = 0;

      // Empty list.
      launch(16'h0000, 32'h600, 4'd0, 1'b1, 1'b1);
      wait_done();
      chk("lit_t5_req_cycles", req_cnt, 0);
      chk("lit_t5_nwrites", log_idx.size(), 0);
      chk("lit_t5_done_lat", done_cyc - start_cyc, 2);

      // Reset after the first write of a 4-register LDM.
      launch(16'h00F0, 32'h500, 4'd1, 1'b1, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (writeBackEn !== 1'b1 && n < 20);
      chk("lit_t6_first_write", writeBackEn, 1);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("lit_t6_rst_outputs", {busy, mem_req, writeBackEn, done}, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("lit_t6_stays_idle", {busy, mem_req, writeBackEn}, 0);
      chk("lit_t6_nwrites", log_idx.size(), 1);

      launch(16'h000F, 32'h700, 4'd6, 1'b1, 1'b1);
      wait_done();
      chk("lit_t6_after_nwrites", log_idx.size(), 5);
      chk("lit_t6_after_base", {log_idx[4], log_data[4]}, {4'd6, 32'h710});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
